morse_symbol_decoder: RTL and testbench
=======================================

# morse_symbol_decoder

Parametrised Morse key decoder that turns a raw key line into complete characters: element code, element count and error flag. It replaces the fixed-timing, single-character input logic in the trainer top level. It adds configurable dot/dash/gap thresholds, a glitch filter and characters of up to MAX_LEN elements. Decoded characters are buffered in a FIFO and delivered over a valid/ready interface, so the checker or display logic can consume them at its own pace.

## Interface
- CNT_W, 8: duration timer width; timer saturates at 2^CNT_W-1.
- DOT_MIN, 20: minimum mark length (cycles) accepted as an element; shorter marks are glitches.
- DASH_MIN, 60: mark length at or above which the element is a dash.
- CHAR_GAP, 40: consecutive space cycles that terminate a character.
- MAX_LEN, 6: maximum elements per character.
- FIFO_DEPTH, 4: output FIFO entries; power of 2, at least 2.
- Constraint: 0 < DOT_MIN < DASH_MIN < 2^CNT_W-1, and CHAR_GAP < 2^CNT_W-1.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; one clock; reset is asynchronous and active-low
- en_i  in  1  decoder enable; low aborts the character in progress
- morse_i  in  1  raw key, asynchronous, high = key down
- sym_code_o  out  MAX_LEN  element bits, 1 = dash; LSB = last element; unused upper bits 0
- sym_len_o  out  $clog2(MAX_LEN+1)  element count, 1..MAX_LEN
- sym_err_o  out  1  character had overflow or stuck key
- sym_valid_o  out  1  FIFO head valid
- sym_ready_i  in  1  consumer accepts head
- busy_o  out  1  FSM not in IDLE
- drop_o  out  1  one-cycle pulse when a completed character is lost because the FIFO is full

## Operation
- morse_i passes through a 2-flop synchroniser to give key_s. All decoding uses key_s.
- Timer: loads 1 on each FSM state entry, then increments every cycle with saturation. It therefore equals the number of cycles key_s has held its current level.
- Per-character state: shift register, length, and a sticky err flag. All are cleared on entry to IDLE.
- IDLE:
  - key_s high and en_i high → MARK.
- MARK:
  - key_s low, D = timer:
    - D < DOT_MIN: glitch, discarded. Go to SPACE if len > 0, else IDLE.
    - DOT_MIN ≤ D < DASH_MIN: shift in 0.
    - D ≥ DASH_MIN: shift in 1.
    - After a shift, go to SPACE.
  - Shift when len == MAX_LEN: set err, code and len unchanged.
  - Timer saturates while key_s is still high: commit the character with err=1, go to HOLD.
- SPACE:
  - key_s high → MARK.
  - CHAR_GAP-th consecutive low cycle: commit, go to IDLE.
- HOLD:
  - Wait for key_s low → IDLE. No elements are recorded.
- Commit:
  - Writes {err, len, code} to the FIFO.
  - If the FIFO is full and there is no pop in the same cycle, the character is discarded and drop_o pulses.
  - A commit with len == 0 occurs only for a stuck key from IDLE; it is written with len=0, err=1.
- en_i low: any state → IDLE the next cycle. The partial character is discarded with no push and no drop. FIFO contents are retained.
- FIFO:
  - Show-ahead: the head is driven on the sym_* outputs.
  - Pop on sym_valid_o && sym_ready_i.
  - Data and valid are held stable while valid && !ready.
  - Push and pop in the same cycle are both honoured, including when full and when empty. When empty, the head updates the next cycle.
  - Pointers wrap modulo FIFO_DEPTH. Count width is $clog2(FIFO_DEPTH)+1.

## Timing
- Reset:
  - FSM goes to IDLE and the FIFO empties.
  - sym_code_o=0, sym_len_o=0, sym_err_o=0, sym_valid_o=0, busy_o=0, drop_o=0.
  - Reset may assert mid-character; no partial output appears after release.
- morse_i edge → key_s edge: 2 cycles.
- Commit cycle → sym_valid_o high: next cycle, when the FIFO was empty.
- Pop: sym_valid_o/data reflect the new head in the cycle after the pop.
- busy_o is registered from state; it is high the cycle after leaving IDLE.
- drop_o is a registered pulse, exactly 1 cycle per lost character.
- A mark is measured on the first low cycle of key_s. A space of exactly CHAR_GAP-1 cycles followed by a mark continues the same character.

## Test plan
- 'A': mark 25, space 15, mark 70, then low ≥ 40 → one entry: code 6'b000001, len 2, err 0. sym_valid_o rises CHAR_GAP+3 cycles after the final falling edge on morse_i.
- Glitch then 'E': mark 5, space 10, mark 30, long space → single entry: code 0, len 1, err 0.
- Overflow: 7 dots (mark 30 / space 15) then gap → code 6'b000000, len 6, err 1.
- Stuck key: morse_i high for 300 cycles → one entry with err 1 and len 0, FSM in HOLD. No further entry until release; after release, 'T' (mark 70) decodes normally.
- FIFO: sym_ready_i=0, send 5 'E's → 4 entries stored, drop_o pulses once. Raising ready pops 4 in order, then valid=0. A commit in the same cycle as a pop when full is stored with no drop.
- en_i low during the second element of 'A' → no entry and no drop. busy_o falls 2 cycles after en_i falls.

Source files
------------

// File: rtl/morse_symbol_decoder.sv
// Morse key decoder: synchronises the raw key, times marks and spaces, assembles
// characters of up to MAX_LEN elements and queues them in a show-ahead FIFO.
module morse_symbol_decoder #(
    parameter int CNT_W      = 8,
    parameter int DOT_MIN    = 20,
    parameter int DASH_MIN   = 60,
    parameter int CHAR_GAP   = 40,
    parameter int MAX_LEN    = 6,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         en_i,
    input  logic                         morse_i,
    output logic [MAX_LEN-1:0]           sym_code_o,
    output logic [$clog2(MAX_LEN+1)-1:0] sym_len_o,
    output logic                         sym_err_o,
    output logic                         sym_valid_o,
    input  logic                         sym_ready_i,
    output logic                         busy_o,
    output logic                         drop_o
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int ENT_W = 1 + LEN_W + MAX_LEN;
    localparam logic [CNT_W-1:0] T_MAX      = '1;
    localparam logic [CNT_W-1:0] DOT_MIN_C  = CNT_W'(DOT_MIN);
    localparam logic [CNT_W-1:0] DASH_MIN_C = CNT_W'(DASH_MIN);
    localparam logic [CNT_W-1:0] GAP_C      = CNT_W'(CHAR_GAP);
    localparam logic [LEN_W-1:0] MAX_LEN_C  = LEN_W'(MAX_LEN);
    localparam logic [PTR_W:0]   DEPTH_C    = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, MARK, SPACE, HOLD} state_e;

    state_e             state_q, state_d;
    logic               sync1_q, key_s_q;
    logic [CNT_W-1:0]   timer_q, timer_d;
    logic [MAX_LEN-1:0] code_q, code_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               err_q, err_d;
    logic               busy_q, drop_q;
    logic               commit, commit_err;

    logic [ENT_W-1:0]   mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]     count_q;
    logic               fifo_empty, fifo_full, push, pop;
    logic [ENT_W-1:0]   head;

    always_comb begin
        state_d    = state_q;
        code_d     = code_q;
        len_d      = len_q;
        err_d      = err_q;
        commit     = 1'b0;
        commit_err = err_q;
        if (!en_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (key_s_q) state_d = MARK;
                MARK: begin
                    if (!key_s_q) begin
                        if (timer_q < DOT_MIN_C) begin
                            state_d = (len_q != '0) ? SPACE : IDLE;
                        end else begin
                            state_d = SPACE;
                            if (len_q == MAX_LEN_C) begin
                                err_d = 1'b1;
                            end else begin
                                code_d = MAX_LEN'({code_q, (timer_q >= DASH_MIN_C)});
                                len_d  = len_q + LEN_W'(1);
                            end
                        end
                    end else if (timer_q == T_MAX) begin
                        // Key stuck down: report what we have, then ignore it until release.
                        commit     = 1'b1;
                        commit_err = 1'b1;
                        state_d    = HOLD;
                    end
                end
                SPACE: begin
                    if (key_s_q) begin
                        state_d = MARK;
                    end else if (timer_q >= GAP_C) begin
                        commit  = 1'b1;
                        state_d = IDLE;
                    end
                end
                HOLD: if (!key_s_q) state_d = IDLE;
            endcase
        end
        if (state_d == IDLE) begin
            code_d = '0;
            len_d  = '0;
            err_d  = 1'b0;
        end
    end

    always_comb begin
        timer_d = timer_q;
        if (state_d != state_q) begin
            timer_d = CNT_W'(1);
        end else if (timer_q != T_MAX) begin
            timer_d = timer_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            key_s_q <= 1'b0;
            state_q <= IDLE;
            timer_q <= '0;
            code_q  <= '0;
            len_q   <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            sync1_q <= morse_i;
            key_s_q <= sync1_q;
            state_q <= state_d;
            timer_q <= timer_d;
            code_q  <= code_d;
            len_q   <= len_d;
            err_q   <= err_d;
            busy_q  <= (state_q != IDLE);
            drop_q  <= commit && fifo_full && !pop;
        end
    end

    // A full FIFO still accepts a commit when the head is popped in the same cycle.
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == DEPTH_C);
    assign pop        = !fifo_empty && sym_ready_i;
    assign push       = commit && (!fifo_full || pop);

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= {commit_err, len_q, code_q};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (push && !pop)      count_q <= count_q + (PTR_W + 1)'(1);
            else if (pop && !push) count_q <= count_q - (PTR_W + 1)'(1);
        end
    end

    assign head        = fifo_empty ? '0 : mem_q[rd_ptr_q];
    assign sym_err_o   = head[ENT_W-1];
    assign sym_len_o   = head[MAX_LEN +: LEN_W];
    assign sym_code_o  = head[MAX_LEN-1:0];
    assign sym_valid_o = !fifo_empty;
    assign busy_o      = busy_q;
    assign drop_o      = drop_q;
endmodule

// File: tb/tb_morse_symbol_decoder.sv
// Directed bench for morse_symbol_decoder: expected characters go into a queue,
// a monitor pops and compares every entry the decoder hands over.
module tb_morse_symbol_decoder;
    logic       clk_i = 1'b0;
    logic       rst_ni, en_i, morse_i, sym_ready_i;
    logic [5:0] sym_code_o;
    logic [2:0] sym_len_o;
    logic       sym_err_o, sym_valid_o, busy_o, drop_o;

    int tests_run    = 0;
    int tests_failed = 0;
    int drop_cnt     = 0;
    int lat;
    logic [9:0] exp_q[$];

    // clock / reset
    always #5 clk_i = ~clk_i;

    morse_symbol_decoder dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .en_i        (en_i),
        .morse_i     (morse_i),
        .sym_code_o  (sym_code_o),
        .sym_len_o   (sym_len_o),
        .sym_err_o   (sym_err_o),
        .sym_valid_o (sym_valid_o),
        .sym_ready_i (sym_ready_i),
        .busy_o      (busy_o),
        .drop_o      (drop_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    function automatic logic [9:0] ent(input logic err, input logic [2:0] len, input logic [5:0] code);
        return {err, len, code};
    endfunction

    // driver tasks: inputs change 1 time unit after the rising edge
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic send_elems(input logic [5:0] code, input int len);
        for (int i = len - 1; i >= 0; i--) begin
            morse_i = 1'b1;
            tick(code[i] ? 70 : 30);
            morse_i = 1'b0;
            if (i != 0) tick(15);
        end
    endtask

    task automatic send_char(input logic [5:0] code, input int len);
        send_elems(code, len);
        tick(50);
    endtask

    // scoreboard monitor
    always @(negedge clk_i) begin
        if (drop_o) drop_cnt++;
        if (rst_ni && sym_valid_o && sym_ready_i) begin
            if (exp_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("FAIL unexpected_entry: got %0h, required no entry",
                         {sym_err_o, sym_len_o, sym_code_o});
            end else begin
                check("entry", {22'b0, sym_err_o, sym_len_o, sym_code_o}, {22'b0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        rst_ni = 1'b0;
        en_i = 1'b1;
        morse_i = 1'b0;
        sym_ready_i = 1'b1;
        tick(3);
        check("rst_valid", sym_valid_o, 0);
        check("rst_code", sym_code_o, 0);
        check("rst_len", sym_len_o, 0);
        check("rst_err", sym_err_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_drop", drop_o, 0);
        rst_ni = 1'b1;
        tick(3);
        check("idle_busy", busy_o, 0);

        // 'A' with output latency measured from the last falling edge
        exp_q.push_back(ent(1'b0, 3'd2, 6'b000001));
        send_elems(6'b000001, 2);
        lat = 0;
        for (int i = 1; i <= 60; i++) begin
            tick(1);
            if (sym_valid_o && lat == 0) lat = i;
        end
        check("a_latency", lat, 43);
        tick(10);

        // glitch followed by 'E'
        exp_q.push_back(ent(1'b0, 3'd1, 6'b000000));
        morse_i = 1'b1;
        tick(5);
        morse_i = 1'b0;
        tick(10);
        send_char(6'b000000, 1);
        tick(5);

        // seven dots overflow a six-element character
        exp_q.push_back(ent(1'b1, 3'd6, 6'b000000));
        for (int i = 0; i < 7; i++) begin
            morse_i = 1'b1;
            tick(30);
            morse_i = 1'b0;
            tick(15);
        end
        tick(50);

        // stuck key, then 'T' after release
        exp_q.push_back(ent(1'b1, 3'd0, 6'b000000));
        morse_i = 1'b1;
        tick(300);
        check("hold_busy", busy_o, 1);
        morse_i = 1'b0;
        tick(20);
        check("hold_release_busy", busy_o, 0);
        exp_q.push_back(ent(1'b0, 3'd1, 6'b000001));
        send_char(6'b000001, 1);
        tick(5);
        check("no_drop_yet", drop_cnt, 0);

        // five 'E's into a four-entry FIFO with the consumer stalled
        sym_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) exp_q.push_back(ent(1'b0, 3'd1, 6'b000000));
        for (int i = 0; i < 5; i++) send_char(6'b000000, 1);
        check("drop_full", drop_cnt, 1);
        check("full_valid", sym_valid_o, 1);
        sym_ready_i = 1'b1;
        tick(10);
        check("drained_valid", sym_valid_o, 0);

        // commit lands in the same cycle as a pop from a full FIFO
        sym_ready_i = 1'b0;
        exp_q.push_back(ent(1'b0, 3'd1, 6'b000000));
        exp_q.push_back(ent(1'b0, 3'd1, 6'b000001));
        exp_q.push_back(ent(1'b0, 3'd2, 6'b000000));
        exp_q.push_back(ent(1'b0, 3'd2, 6'b000011));
        send_char(6'b000000, 1);
        send_char(6'b000001, 1);
        send_char(6'b000000, 2);
        send_char(6'b000011, 2);
        exp_q.push_back(ent(1'b0, 3'd2, 6'b000001));
        send_elems(6'b000001, 2);
        tick(42);
        sym_ready_i = 1'b1;
        tick(1);
        sym_ready_i = 1'b0;
        tick(5);
        check("pop_push_no_drop", drop_cnt, 1);
        sym_ready_i = 1'b1;
        tick(10);
        check("pop_push_drained", sym_valid_o, 0);

        // enable drops during the second element of 'A'
        morse_i = 1'b1;
        tick(25);
        morse_i = 1'b0;
        tick(15);
        morse_i = 1'b1;
        tick(30);
        en_i = 1'b0;
        tick(1);
        check("en_busy_k1", busy_o, 1);
        tick(1);
        check("en_busy_k2", busy_o, 0);
        tick(40);
        morse_i = 1'b0;
        tick(10);
        en_i = 1'b1;
        tick(100);
        check("en_no_drop", drop_cnt, 1);
        check("en_no_entry", sym_valid_o, 0);

        // reset in the middle of a character
        morse_i = 1'b1;
        tick(30);
        morse_i = 1'b0;
        tick(15);
        morse_i = 1'b1;
        tick(20);
        rst_ni = 1'b0;
        morse_i = 1'b0;
        tick(2);
        rst_ni = 1'b1;
        tick(80);
        check("midrst_valid", sym_valid_o, 0);
        check("midrst_busy", busy_o, 0);

        check("leftover_expected", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
